// File: rtl/result_uart_tx.sv
// result_uart_tx
//   Transmit end of the host link. Takes sorted result words from the sorter
//   output stage and serialises each one onto the UART tx pin as DATA_WIDTH/8
//   bytes. Bytes go out least-significant first. Each byte is an 8N1 frame,
//   and the bits within a byte are sent LSB first.
//
// Ports
//   clk_i    system clock; all state changes on the rising edge
//   rst_ni   asynchronous active-low reset (release is expected to be synchronous)
//   data_i   result word to transmit
//   valid_i  data_i is valid
//   ready_o  a word can be accepted (high only while idle)
//   tx_o     registered UART serial output, idles high
//   busy_o   a word is being sent (state != IDLE)
//   words_o  count of fully transmitted words, wraps 0xFFFF -> 0
module result_uart_tx #(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic [15:0]           words_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int BYTES        = DATA_WIDTH / 8;
    localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam int BYTE_W       = (BYTES < 2) ? 1 : $clog2(BYTES);

    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("result_uart_tx: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
    end
    if ((DATA_WIDTH < 8) || (DATA_WIDTH % 8 != 0)) begin : g_bad_width
        $error("result_uart_tx: DATA_WIDTH must be a non-zero multiple of 8");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        baud_q;
    logic [2:0]              bit_q;
    logic [BYTE_W-1:0]       byte_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    tx_q;
    logic [15:0]             words_q;
    logic                    bit_end;
    logic                    accept;

    assign bit_end = (baud_q == BAUD_LAST);
    assign accept  = valid_i && (state_q == IDLE);

    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q != IDLE);
    assign tx_o    = tx_q;
    assign words_o = words_q;

    // Word buffer. It is loaded only on acceptance, so changes on data_i
    // mid-frame cannot reach the line. It shifts right once per data bit.
    // After 8 shifts the next byte sits in bits [7:0].
    always_ff @(posedge clk_i) begin
        if (accept) begin
            shift_q <= data_i;
        end else if ((state_q == DATA) && bit_end) begin
            shift_q <= shift_q >> 1;
        end
    end

    // Frame sequencer. tx_q is loaded one edge ahead of each bit period, so
    // every level on the line is held for exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
            words_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        state_q <= START;
                        baud_q  <= '0;
                        byte_q  <= '0;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            // shift_q moves right on this same edge, so the
                            // next bit is still at index 1 here
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (byte_q != BYTE_LAST) begin
                            // the next byte's start bit follows directly, with no idle gap
                            byte_q  <= byte_q + BYTE_W'(1);
                            state_q <= START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            words_q <= words_q + 16'd1;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule
